// File: rtl/dlx_pkg.sv
// dlx_pkg: shared ALU opcodes, DLX opcode/func constants and decode/buffer types
package dlx_pkg;
  localparam logic [4:0] ALU_AND  = 5'h00;
  localparam logic [4:0] ALU_OR   = 5'h01;
  localparam logic [4:0] ALU_ADD  = 5'h02;
  localparam logic [4:0] ALU_SUB  = 5'h03;
  localparam logic [4:0] ALU_XOR  = 5'h04;
  localparam logic [4:0] ALU_SLL  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SLTU = 5'h07;
  localparam logic [4:0] ALU_SLT  = 5'h08;
  localparam logic [4:0] ALU_SGE  = 5'h09;
  localparam logic [4:0] ALU_SGT  = 5'h0A;
  localparam logic [4:0] ALU_LHI  = 5'h0C;
  localparam logic [4:0] ALU_MOV  = 5'h1F;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_SUBUI = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SLTI  = 6'h1A;
  localparam logic [5:0] OP_SGTI  = 6'h1B;
  localparam logic [5:0] OP_SGEI  = 6'h1D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h04;
  localparam logic [5:0] FN_SRL   = 6'h06;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SGT   = 6'h2B;
  localparam logic [5:0] FN_SGE   = 6'h2D;
  localparam logic [5:0] FN_SLTU  = 6'h3A;
  localparam logic [5:0] FN_MOV   = 6'h3F;
  typedef struct packed {
    logic [4:0] op;
    logic       imm_sel;
    logic       sext;
    logic [4:0] rd;
    logic       wb_en;
    logic       illegal;
  } dec_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} buf_state_t;
endpackage

// File: rtl/dlx_alu_decode.sv
// dlx_alu_decode: combinational DLX instruction to ALU control decode
module dlx_alu_decode
  import dlx_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [5:0] opc, fn;
  logic unused_fields;
  assign opc = instr[31:26];
  assign fn = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[10:6]};
  always_comb begin
    dec = '{op: ALU_ADD, imm_sel: 1'b1, sext: 1'b1, rd: instr[20:16], wb_en: 1'b1, illegal: 1'b0};
    if (opc == OP_RTYPE) begin
      dec.imm_sel = 1'b0;
      dec.rd = instr[15:11];
      case (fn)
        FN_ADD, FN_ADDU: dec.op = ALU_ADD;
        FN_SUB, FN_SUBU: dec.op = ALU_SUB;
        FN_AND:  dec.op = ALU_AND;
        FN_OR:   dec.op = ALU_OR;
        FN_XOR:  dec.op = ALU_XOR;
        FN_SLL:  dec.op = ALU_SLL;
        FN_SRL:  dec.op = ALU_SRL;
        FN_SLT:  dec.op = ALU_SLT;
        FN_SGT:  dec.op = ALU_SGT;
        FN_SGE:  dec.op = ALU_SGE;
        FN_SLTU: dec.op = ALU_SLTU;
        FN_MOV:  dec.op = ALU_MOV;
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      case (opc)
        OP_ADDI, OP_ADDUI, OP_LW: dec.op = ALU_ADD;
        OP_SW: begin
          dec.op = ALU_ADD;
          dec.wb_en = 1'b0;
        end
        OP_SUBI, OP_SUBUI: dec.op = ALU_SUB;
        OP_ANDI: dec.op = ALU_AND;
        OP_ORI:  dec.op = ALU_OR;
        OP_XORI: dec.op = ALU_XOR;
        OP_LHI:  dec.op = ALU_LHI;
        OP_SLLI: dec.op = ALU_SLL;
        OP_SRLI: dec.op = ALU_SRL;
        OP_SLTI: dec.op = ALU_SLT;
        OP_SGTI: dec.op = ALU_SGT;
        OP_SGEI: dec.op = ALU_SGE;
        default: dec.illegal = 1'b1;
      endcase
      dec.sext = !(opc inside {OP_ANDI, OP_ORI, OP_XORI, OP_LHI, OP_SLLI, OP_SRLI});
    end
    dec.op = dec.illegal ? ALU_ADD : dec.op;
    dec.wb_en = dec.wb_en && !dec.illegal && (dec.rd != 5'd0);
  end
endmodule

// File: rtl/dlx_alu_issue.sv
// dlx_alu_issue: EX issue register with operand mux and two-entry skid buffer
module dlx_alu_issue
  import dlx_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [DW-1:0] in_rs1_data,
  input  logic [DW-1:0] in_rs2_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_op,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [4:0]    out_rd,
  output logic          out_wb_en,
  output logic          out_illegal
);
  typedef struct packed {
    logic [4:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    rd;
    logic          wb_en;
    logic          illegal;
  } issue_t;
  dec_t dec;
  issue_t new_p, main_d, main_q, skid_d, skid_q;
  buf_state_t state_d, state_q;
  logic [DW-1:0] imm, b_sel;
  logic accept, drain;
  dlx_alu_decode u_dec (.instr(in_instr), .dec(dec));
  assign imm = dec.sext ? {{(DW-16){in_instr[15]}}, in_instr[15:0]} : {{(DW-16){1'b0}}, in_instr[15:0]};
  assign b_sel = (dec.op == ALU_MOV) ? '0 : dec.imm_sel ? imm : in_rs2_data;
  assign new_p = '{op: dec.op, a: in_rs1_data, b: b_sel, rd: dec.rd, wb_en: dec.wb_en, illegal: dec.illegal};
  // in_ready comes straight from the state flop, so out_ready never reaches it combinationally
  assign in_ready = state_q != ST_TWO;
  assign out_valid = state_q != ST_EMPTY;
  assign accept = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  assign {out_op, out_a, out_b, out_rd, out_wb_en, out_illegal} = main_q;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d = '0;
      skid_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          main_d = accept ? new_p : main_q;
          state_d = accept ? ST_ONE : ST_EMPTY;
        end
        ST_ONE: begin
          main_d = (accept && drain) ? new_p : main_q;
          skid_d = (accept && !drain) ? new_p : skid_q;
          state_d = (accept && !drain) ? ST_TWO : (drain && !accept) ? ST_EMPTY : ST_ONE;
        end
        ST_TWO: begin
          main_d = drain ? skid_q : main_q;
          state_d = drain ? ST_ONE : ST_TWO;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: tb/tb_dlx_alu_issue.sv
// tb_dlx_alu_issue: vector table, directed skid sequences and random scoreboard check
module tb_dlx_alu_issue;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_wb_en, out_illegal;
  logic [31:0] in_instr = '0, in_rs1_data = '0, in_rs2_data = '0, out_a, out_b;
  logic [4:0] out_op, out_rd;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [4:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] rd;
    logic wb;
    logic il;
  } pay_t;
  typedef struct {
    logic [31:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
    pay_t exp;
  } vec_t;
  pay_t q[$];
  vec_t vt[15];
  logic [5:0] opcs[20] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                           6'h0F, 6'h14, 6'h16, 6'h1A, 6'h1B, 6'h1D, 6'h23, 6'h2B, 6'h3E, 6'h01};
  logic [5:0] fns[14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h2A,
                          6'h2B, 6'h2D, 6'h3A, 6'h3F};

  dlx_alu_issue #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rt(int s1, int s2, int d, logic [5:0] fn);
    return {6'h00, 5'(s1), 5'(s2), 5'(d), 5'd0, fn};
  endfunction

  function automatic logic [31:0] it(logic [5:0] opc, int s1, int d, logic [15:0] imm);
    return {opc, 5'(s1), 5'(d), imm};
  endfunction

  // Reference decode straight from the instruction tables
  function automatic pay_t ref_pay(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2);
    pay_t p;
    logic [5:0] opc = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic rtype = (opc == 6'h00);
    logic legal = 1'b1;
    logic zext = 1'b0;
    int op = 2;
    if (rtype) begin
      case (fn)
        6'h20, 6'h21: op = 2;
        6'h22, 6'h23: op = 3;
        6'h24: op = 0;
        6'h25: op = 1;
        6'h26: op = 4;
        6'h04: op = 5;
        6'h06: op = 6;
        6'h2A: op = 8;
        6'h2B: op = 10;
        6'h2D: op = 9;
        6'h3A: op = 7;
        6'h3F: op = 31;
        default: legal = 1'b0;
      endcase
    end else begin
      case (opc)
        6'h08, 6'h09, 6'h23, 6'h2B: op = 2;
        6'h0A, 6'h0B: op = 3;
        6'h0C: begin op = 0; zext = 1'b1; end
        6'h0D: begin op = 1; zext = 1'b1; end
        6'h0E: begin op = 4; zext = 1'b1; end
        6'h0F: begin op = 12; zext = 1'b1; end
        6'h14: begin op = 5; zext = 1'b1; end
        6'h16: begin op = 6; zext = 1'b1; end
        6'h1A: op = 8;
        6'h1B: op = 10;
        6'h1D: op = 9;
        default: legal = 1'b0;
      endcase
    end
    p.op = legal ? 5'(op) : 5'd2;
    p.a = r1;
    p.rd = rtype ? ins[15:11] : ins[20:16];
    if (rtype) p.b = (legal && fn == 6'h3F) ? 32'd0 : r2;
    else p.b = zext ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    p.wb = legal && (p.rd != 0) && !(!rtype && opc == 6'h2B);
    p.il = !legal;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_pay(input string nm, input pay_t e);
    chk({nm, ".op"}, 64'(out_op), 64'(e.op));
    chk({nm, ".a"}, 64'(out_a), 64'(e.a));
    chk({nm, ".b"}, 64'(out_b), 64'(e.b));
    chk({nm, ".rd"}, 64'(out_rd), 64'(e.rd));
    chk({nm, ".wb_en"}, 64'(out_wb_en), 64'(e.wb));
    chk({nm, ".illegal"}, 64'(out_illegal), 64'(e.il));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    cmp_pay(nm, '0);
  endtask

  // One cycle: drive, compare against the scoreboard, then update the model at the edge
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                      input logic ordy, input logic fl, input logic rn);
    logic acc, drn;
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_rs1_data = r1; in_rs2_data = r2;
    out_ready = ordy; flush = fl; rst_n = rn;
    #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) cmp_pay("head", q[0]);
    acc = iv && in_ready;
    drn = out_valid && ordy;
    @(posedge clk);
    if (!rn || fl) q.delete();
    else begin
      if (drn && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(ref_pay(ins, r1, r2));
    end
  endtask

  initial begin
    pay_t held;
    logic [31:0] ri;
    vt[0]  = '{rt(1, 2, 3, 6'h20), 32'd5, 32'd7, '{5'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}};
    vt[1]  = '{it(6'h0C, 1, 4, 16'hFFFF), 32'hFFFF0F0F, 32'd0, '{5'd0, 32'hFFFF0F0F, 32'h0000FFFF, 5'd4, 1'b1, 1'b0}};
    vt[2]  = '{it(6'h08, 1, 4, 16'hFFFF), 32'd10, 32'd0, '{5'd2, 32'd10, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0}};
    vt[3]  = '{it(6'h3E, 1, 5, 16'h1234), 32'd3, 32'd0, '{5'd2, 32'd3, 32'h00001234, 5'd5, 1'b0, 1'b1}};
    vt[4]  = '{rt(1, 2, 0, 6'h20), 32'd5, 32'd7, '{5'd2, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0}};
    vt[5]  = '{it(6'h2B, 1, 6, 16'h8000), 32'd100, 32'd9, '{5'd2, 32'd100, 32'hFFFF8000, 5'd6, 1'b0, 1'b0}};
    vt[6]  = '{it(6'h0F, 0, 7, 16'h8001), 32'd0, 32'd0, '{5'd12, 32'd0, 32'h00008001, 5'd7, 1'b1, 1'b0}};
    vt[7]  = '{rt(8, 2, 9, 6'h3F), 32'hAAAA5555, 32'd77, '{5'd31, 32'hAAAA5555, 32'd0, 5'd9, 1'b1, 1'b0}};
    vt[8]  = '{rt(1, 2, 10, 6'h23), 32'd9, 32'd4, '{5'd3, 32'd9, 32'd4, 5'd10, 1'b1, 1'b0}};
    vt[9]  = '{it(6'h1A, 1, 11, 16'hFFFE), 32'd1, 32'd0, '{5'd8, 32'd1, 32'hFFFFFFFE, 5'd11, 1'b1, 1'b0}};
    vt[10] = '{rt(1, 2, 12, 6'h3A), 32'd1, 32'd2, '{5'd7, 32'd1, 32'd2, 5'd12, 1'b1, 1'b0}};
    vt[11] = '{it(6'h16, 1, 13, 16'h8003), 32'h80000000, 32'd0, '{5'd6, 32'h80000000, 32'h00008003, 5'd13, 1'b1, 1'b0}};
    vt[12] = '{rt(1, 2, 14, 6'h3B), 32'd4, 32'd5, '{5'd2, 32'd4, 32'd5, 5'd14, 1'b0, 1'b1}};
    vt[13] = '{it(6'h23, 1, 15, 16'h0004), 32'd100, 32'd0, '{5'd2, 32'd100, 32'd4, 5'd15, 1'b1, 1'b0}};
    vt[14] = '{it(6'h1D, 1, 16, 16'h8000), 32'd6, 32'd0, '{5'd9, 32'd6, 32'hFFFF8000, 5'd16, 1'b1, 1'b0}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");

    foreach (vt[i]) begin
      step(1'b1, vt[i].ins, vt[i].r1, vt[i].r2, 1'b1, 1'b0, 1'b1);
      #1;
      cmp_pay($sformatf("vec%0d", i), vt[i].exp);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    end
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Back-pressure: fill to TWO, hold, release
    step(1'b1, rt(1, 2, 1, 6'h20), 32'h11, 32'h21, 1'b0, 1'b0, 1'b1);
    step(1'b1, rt(1, 2, 2, 6'h22), 32'h12, 32'h22, 1'b0, 1'b0, 1'b1);
    #1;
    chk("stall.in_ready", 64'(in_ready), 64'd0);
    held = '{5'd2, 32'h11, 32'h21, 5'd1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, rt(1, 2, 3, 6'h24), 32'h13, 32'h23, 1'b0, 1'b0, 1'b1);
      #1;
      cmp_pay("stall.hold", held);
    end
    for (int k = 0; k < 5; k++) step(1'b1, rt(1, 2, 3, 6'h24), 32'h13, 32'h23, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Flush while TWO with a new instruction presented
    step(1'b1, rt(1, 2, 4, 6'h25), 32'h14, 32'h24, 1'b0, 1'b0, 1'b1);
    step(1'b1, rt(1, 2, 5, 6'h26), 32'h15, 32'h25, 1'b0, 1'b0, 1'b1);
    step(1'b1, rt(1, 2, 6, 6'h20), 32'hDEAD, 32'hBEEF, 1'b0, 1'b1, 1'b1);
    #1;
    chk_reset_vals("flush");
    step(1'b1, rt(1, 2, 7, 6'h20), 32'h17, 32'h27, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Reset mid-stall
    step(1'b1, rt(1, 2, 8, 6'h20), 32'h18, 32'h28, 1'b0, 1'b0, 1'b1);
    step(1'b1, rt(1, 2, 9, 6'h20), 32'h19, 32'h29, 1'b0, 1'b0, 1'b1);
    step(1'b1, rt(1, 2, 10, 6'h20), 32'h1A, 32'h2A, 1'b0, 1'b0, 1'b0);
    #1;
    chk_reset_vals("rst_mid");

    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      ri[31:26] = opcs[$urandom_range(0, 19)];
      if (ri[31:26] == 6'h00 && $urandom_range(0, 9) != 0) ri[5:0] = fns[$urandom_range(0, 13)];
      step($urandom_range(0, 3) != 0, ri, $urandom, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, 1'b1);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
